pls_cont_mc: RTL and testbench

PLS_CONT_MC -- requirements
Module: pls_cont_mc

---
 rtl/pls_cont_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_pls_cont_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pls_cont_mc.sv
// Multi-axis pulse-train controller. A first-word-fall-through segment FIFO feeds a
// run FSM that waits for a coordinator grant, then emits fixed-width step pulses per axis.
module pls_cont_mc #(
    parameter int unsigned AXES    = 4,
    parameter int unsigned T_WIDTH = 32,
    parameter int unsigned L_WIDTH = 32,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned PW      = 4
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    abort,
    input  logic                    brake,
    input  logic                    oi,
    output logic                    oi_req,
    input  logic                    wrreq,
    input  logic                    sop_in,
    input  logic                    eop_in,
    input  logic [AXES-1:0]         mask_in,
    input  logic [AXES-1:0]         dir_in,
    input  logic [AXES*T_WIDTH-1:0] t_in,
    input  logic [L_WIDTH-1:0]      len_in,
    output logic                    full,
    output logic                    ready,
    output logic                    run,
    output logic                    err,
    output logic                    seg_done,
    output logic [AXES-1:0]         pls,
    output logic [AXES-1:0]         dir
);
    localparam int unsigned DEPTH = 2**FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned HI_W  = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [T_WIDTH-1:0] T_MIN = T_WIDTH'(2*PW);

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [AXES-1:0]         mask;
        logic [AXES-1:0]         dir;
        logic [AXES*T_WIDTH-1:0] t;
        logic [L_WIDTH-1:0]      len;
    } seg_t;

    typedef enum logic [2:0] {S_IDLE, S_SOP_CHK, S_OI_WAIT, S_RUN, S_ERR} state_t;

    state_t               r_state;
    seg_t                 r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full, r_ready, r_run, r_err, r_seg_done, r_eop;
    logic [L_WIDTH-1:0]   r_len, r_seg_cnt;
    logic [AXES-1:0]      r_act, r_pls, r_dir;
    logic [T_WIDTH-1:0]   r_ph [AXES];
    logic [T_WIDTH-1:0]   r_teff_m1 [AXES];
    logic [HI_W-1:0]      r_hi_cnt [AXES];

    seg_t                 w_wr_data, w_head;
    logic                 w_empty, w_stop, w_wr, w_pop, w_seg_end, w_load;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [T_WIDTH-1:0]   w_head_t [AXES];
    logic [T_WIDTH-1:0]   w_teff_m1 [AXES];
    logic [T_WIDTH-1:0]   w_ph_nxt [AXES];
    logic [AXES-1:0]      w_fire;

    assign w_wr_data = {sop_in, eop_in, mask_in, dir_in, t_in, len_in};
    assign w_head    = r_mem[r_rptr];
    assign w_empty   = (r_count == '0);
    assign w_stop    = abort | brake;
    assign w_wr      = wrreq & ~r_full & ~w_stop;
    assign w_seg_end = (r_len == '0) || (r_seg_cnt == r_len - L_WIDTH'(1));

    // Head consumption: discard stray words, accept grant, or chain into the next segment
    always_comb begin
        w_pop  = 1'b0;
        w_load = 1'b0;
        if (!w_stop && !w_empty) begin
            case (r_state)
                S_SOP_CHK: w_pop = ~w_head.sop;
                S_OI_WAIT: begin
                    w_pop  = oi;
                    w_load = oi && (w_head.mask != '0) && (w_head.len != '0);
                end
                S_RUN: begin
                    w_pop  = w_seg_end & ~r_eop;
                    w_load = w_seg_end & ~r_eop;
                end
                default: w_pop = 1'b0;
            endcase
        end
    end

    assign w_count_nxt = w_stop ? '0 : (r_count + CNT_W'(w_wr) - CNT_W'(w_pop));

    // Per-axis period decode and phase advance; a pulse never starts on the segment's final edge
    always_comb begin
        for (int i = 0; i < int'(AXES); i++) begin
            w_head_t[i]  = w_head.t[i*T_WIDTH +: T_WIDTH];
            w_teff_m1[i] = ((w_head_t[i] < T_MIN) ? T_MIN : w_head_t[i]) - T_WIDTH'(1);
            w_ph_nxt[i]  = (r_ph[i] == r_teff_m1[i]) ? '0 : r_ph[i] + T_WIDTH'(1);
            w_fire[i]    = (r_state == S_RUN) && r_act[i] && !w_seg_end &&
                           (w_ph_nxt[i] == r_teff_m1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_wr_data;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_ready    <= 1'b1;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
            r_seg_done <= 1'b0;
            r_eop      <= 1'b0;
            r_len      <= '0;
            r_seg_cnt  <= '0;
            r_act      <= '0;
            r_pls      <= '0;
            r_dir      <= '0;
            for (int i = 0; i < int'(AXES); i++) begin
                r_ph[i]      <= '0;
                r_teff_m1[i] <= '0;
                r_hi_cnt[i]  <= '0;
            end
        end else begin
            r_seg_done <= 1'b0;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            if (w_stop) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr)  r_wptr <= r_wptr + FIFO_AW'(1);
                if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
            end

            // Pulse width runs to completion regardless of state, unless stopped below
            for (int i = 0; i < int'(AXES); i++) begin
                if (w_fire[i]) begin
                    r_pls[i]    <= 1'b1;
                    r_hi_cnt[i] <= HI_W'(PW - 1);
                end else if (r_hi_cnt[i] != '0) begin
                    r_hi_cnt[i] <= r_hi_cnt[i] - HI_W'(1);
                end else begin
                    r_pls[i] <= 1'b0;
                end
                if (r_state == S_RUN) r_ph[i] <= w_ph_nxt[i];
            end
            if (r_state == S_RUN && r_seg_cnt != '1) r_seg_cnt <= r_seg_cnt + L_WIDTH'(1);

            if (w_load) begin
                r_eop     <= w_head.eop;
                r_len     <= w_head.len;
                r_seg_cnt <= '0;
                for (int i = 0; i < int'(AXES); i++) begin
                    r_act[i]     <= w_head.mask[i] && (w_head_t[i] != '0);
                    r_teff_m1[i] <= w_teff_m1[i];
                    r_ph[i]      <= '0;
                    if (w_head.mask[i] && (w_head_t[i] != '0)) r_dir[i] <= w_head.dir[i];
                end
            end

            if (abort || brake) begin
                r_state <= abort ? S_ERR : S_IDLE;
                r_err   <= abort;
                r_run   <= 1'b0;
                r_ready <= 1'b1;
                r_pls   <= '0;
                for (int i = 0; i < int'(AXES); i++) r_hi_cnt[i] <= '0;
            end else begin
                case (r_state)
                    S_IDLE:    if (!w_empty) r_state <= S_SOP_CHK;
                    S_SOP_CHK: r_state <= w_head.sop ? S_OI_WAIT : S_IDLE;
                    S_OI_WAIT: begin
                        if (oi && w_load) begin
                            r_state <= S_RUN;
                            r_run   <= 1'b1;
                            r_ready <= 1'b0;
                        end else if (oi) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        if (w_seg_end) begin
                            r_seg_done <= 1'b1;
                            if (r_eop) begin
                                r_state <= S_IDLE;
                                r_run   <= 1'b0;
                                r_ready <= 1'b1;
                            end else if (w_empty) begin
                                r_state <= S_ERR;
                                r_run   <= 1'b0;
                                r_err   <= 1'b1;
                                r_ready <= 1'b1;
                            end
                        end
                    end
                    S_ERR:   r_state <= S_ERR;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign oi_req   = (r_state == S_OI_WAIT);
    assign full     = r_full;
    assign ready    = r_ready;
    assign run      = r_run;
    assign err      = r_err;
    assign seg_done = r_seg_done;
    assign pls      = r_pls;
    assign dir      = r_dir;

endmodule

// File: tb/tb_pls_cont_mc.sv
// Directed bench for pls_cont_mc: two instances (PW=4 and PW=2) share one stimulus stream.
module tb_pls_cont_mc;
    logic         clk = 1'b0;
    logic         aclr, abort, brake, oi, wrreq, sop_in, eop_in;
    logic [3:0]   mask_in, dir_in;
    logic [127:0] t_in;
    logic [31:0]  len_in;

    logic         oi_req_a, full_a, ready_a, run_a, err_a, seg_done_a;
    logic [3:0]   pls_a, dir_a;
    logic         oi_req_b, full_b, ready_b, run_b, err_b, seg_done_b;
    logic [3:0]   pls_b, dir_b;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pls_cont_mc #(.AXES(4), .T_WIDTH(32), .L_WIDTH(32), .FIFO_AW(2), .PW(4)) u_a (
        .clk(clk), .aclr(aclr), .abort(abort), .brake(brake), .oi(oi), .oi_req(oi_req_a),
        .wrreq(wrreq), .sop_in(sop_in), .eop_in(eop_in), .mask_in(mask_in), .dir_in(dir_in),
        .t_in(t_in), .len_in(len_in), .full(full_a), .ready(ready_a), .run(run_a),
        .err(err_a), .seg_done(seg_done_a), .pls(pls_a), .dir(dir_a)
    );

    pls_cont_mc #(.AXES(4), .T_WIDTH(32), .L_WIDTH(32), .FIFO_AW(2), .PW(2)) u_b (
        .clk(clk), .aclr(aclr), .abort(abort), .brake(brake), .oi(oi), .oi_req(oi_req_b),
        .wrreq(wrreq), .sop_in(sop_in), .eop_in(eop_in), .mask_in(mask_in), .dir_in(dir_in),
        .t_in(t_in), .len_in(len_in), .full(full_b), .ready(ready_b), .run(run_b),
        .err(err_b), .seg_done(seg_done_b), .pls(pls_b), .dir(dir_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic sop, input logic eop, input logic [3:0] m, input logic [3:0] d,
                      input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                      input logic [31:0] t3, input logic [31:0] len);
        wrreq   = 1'b1;
        sop_in  = sop;
        eop_in  = eop;
        mask_in = m;
        dir_in  = d;
        t_in    = {t3, t2, t1, t0};
        len_in  = len;
        tick();
        wrreq   = 1'b0;
    endtask

    // Expected pulse level at cycle k for one segment starting at st (pulse rises at teff-1, 2*teff-1, ...)
    function automatic logic seg_pls(input int k, input int st, input int teff, input int len, input int pw);
        int kk, r;
        kk = k - st;
        if (kk < 0) return 1'b0;
        r = ((kk + 1) / teff) * teff - 1;
        while (r >= len) r -= teff;
        return (r >= 0) && (kk - r < pw);
    endfunction

    initial begin
        aclr = 1'b1; abort = 1'b0; brake = 1'b0; oi = 1'b0; wrreq = 1'b0;
        sop_in = 1'b0; eop_in = 1'b0; mask_in = '0; dir_in = '0; t_in = '0; len_in = '0;
        tick(2);
        chk("rst_full", full_a, 0);      chk("rst_ready", ready_a, 1);
        chk("rst_run", run_a, 0);        chk("rst_err", err_a, 0);
        chk("rst_done", seg_done_a, 0);  chk("rst_oi_req", oi_req_a, 0);
        chk("rst_pls", pls_a, 0);        chk("rst_dir", dir_a, 0);
        chk("rst_ready_b", ready_b, 1);  chk("rst_pls_b", pls_b, 0);

        // Single packet, written on the first edge after reset release
        aclr = 1'b0;
        oi   = 1'b1;
        wr(1, 1, 4'b0001, 4'b1111, 10, 0, 0, 0, 100);
        tick(2);
        chk("t1_oi_req", oi_req_a, 1);
        chk("t1_run_pre", run_a, 0);
        tick();
        chk("t1_dir", dir_a, 4'b0001);
        chk("t1_ready_run", ready_a, 0);
        for (int k = 0; k < 110; k++) begin
            chk($sformatf("t1_pls@%0d", k), pls_a, {3'b000, seg_pls(k, 0, 10, 100, 4)});
            chk($sformatf("t1_run@%0d", k), run_a, (k < 100) ? 1 : 0);
            chk($sformatf("t1_done@%0d", k), seg_done_a, (k == 100) ? 1 : 0);
            tick();
        end
        chk("t1_ready_end", ready_a, 1);

        // Three preloaded segments chained without a gap
        oi = 1'b0;
        wr(1, 0, 4'b0001, 4'b0001, 10, 0, 0, 0, 40);
        wr(0, 0, 4'b0001, 4'b0001, 20, 0, 0, 0, 40);
        wr(0, 1, 4'b0001, 4'b0001, 5, 0, 0, 0, 40);
        chk("t2_oi_req", oi_req_a, 1);
        chk("t2_full", full_a, 0);
        oi = 1'b1;
        tick();
        for (int k = 0; k < 128; k++) begin
            chk($sformatf("t2_pls_a@%0d", k), pls_a[0],
                seg_pls(k, 0, 10, 40, 4) | seg_pls(k, 40, 20, 40, 4) | seg_pls(k, 80, 8, 40, 4));
            chk($sformatf("t2_pls_b@%0d", k), pls_b[0],
                seg_pls(k, 0, 10, 40, 2) | seg_pls(k, 40, 20, 40, 2) | seg_pls(k, 80, 5, 40, 2));
            chk($sformatf("t2_run@%0d", k), run_a, (k < 120) ? 1 : 0);
            chk($sformatf("t2_done@%0d", k), seg_done_a, (k == 40 || k == 80 || k == 120) ? 1 : 0);
            tick();
        end
        chk("t2_ready_end", ready_a, 1);

        // Underflow: continuation arrives after the first segment ends
        wr(1, 0, 4'b0001, 4'b0001, 10, 0, 0, 0, 20);
        tick(2);
        chk("t3_oi_req", oi_req_a, 1);
        tick();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t3_run@%0d", k), run_a, 1);
            tick();
        end
        chk("t3_err", err_a, 1);
        chk("t3_run_off", run_a, 0);
        chk("t3_ready", ready_a, 1);
        chk("t3_done", seg_done_a, 1);
        chk("t3_tail", pls_a, 4'b0001);
        wr(1, 1, 4'b0001, 4'b0001, 10, 0, 0, 0, 20);
        chk("t3_err_hold", err_a, 1);
        tick(3);
        chk("t3_no_consume_run", run_a, 0);
        chk("t3_no_consume_req", oi_req_a, 0);
        brake = 1'b1;
        tick();
        brake = 1'b0;
        chk("t3_brake_err", err_a, 0);
        chk("t3_brake_ready", ready_a, 1);
        tick(4);
        chk("t3_flush_run", run_a, 0);
        chk("t3_flush_req", oi_req_a, 0);

        // Stray head without sop is discarded before the real packet
        oi = 1'b0;
        wr(0, 1, 4'b0001, 4'b0000, 10, 0, 0, 0, 10);
        wr(1, 1, 4'b0010, 4'b1110, 0, 6, 0, 0, 16);
        chk("t4_req_0", oi_req_a, 0);
        tick();
        chk("t4_req_1", oi_req_a, 0);
        tick(2);
        chk("t4_req_2", oi_req_a, 1);
        oi = 1'b1;
        tick();
        chk("t4_run", run_a, 1);
        chk("t4_dir", dir_a, 4'b0011);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t4_pls_a@%0d", k), pls_a, {2'b00, seg_pls(k, 0, 8, 16, 4), 1'b0});
            chk($sformatf("t4_pls_b@%0d", k), pls_b, {2'b00, seg_pls(k, 0, 6, 16, 2), 1'b0});
            tick();
        end

        // Short period is stretched; masked and T=0 axes stay low with dir untouched
        wr(1, 1, 4'b0101, 4'b1010, 0, 7, 3, 9, 20);
        tick(2);
        chk("t5_oi_req", oi_req_a, 1);
        tick();
        chk("t5_dir_a", dir_a, 4'b0011);
        chk("t5_dir_b", dir_b, 4'b0011);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("t5_pls_a@%0d", k), pls_a, {1'b0, seg_pls(k, 0, 8, 20, 4), 2'b00});
            chk($sformatf("t5_pls_b@%0d", k), pls_b, {1'b0, seg_pls(k, 0, 4, 20, 2), 2'b00});
            tick();
        end

        // Abort in the middle of a pulse with the FIFO full
        wr(1, 0, 4'b0001, 4'b0001, 10, 0, 0, 0, 1000);
        tick(3);
        for (int k = 0; k < 4; k++) wr(0, 0, 4'b0001, 4'b0001, 10, 0, 0, 0, 10);
        chk("t6_full", full_a, 1);
        tick(6);
        chk("t6_pls_mid", pls_a, 4'b0001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_err", err_a, 1);
        chk("t6_run", run_a, 0);
        chk("t6_pls", pls_a, 0);
        chk("t6_pls_b", pls_b, 0);
        chk("t6_full_clr", full_a, 0);
        chk("t6_ready", ready_a, 1);
        tick(3);
        chk("t6_err_stay", err_a, 1);
        brake = 1'b1;
        tick();
        brake = 1'b0;
        chk("t6_brake_err", err_a, 0);
        chk("t6_brake_ready", ready_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
